btb_predictor: RTL and testbench

- Parametrised branch target buffer with 2-bit saturating direction counters.
- Replaces the single-entry branch-target/jump buffering in the pipelined RV32I datapath.
- Lookup is combinational from the IF-stage PC. Update comes from the EX-stage branch/jump resolution.
- Also produces the EX-stage mispredict/redirect signal and saturating performance counters.

---
 rtl/btb_predictor.sv | 97 +++++++++
 tb/tb_btb_predictor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit direction counters,
// EX-stage redirect generation and saturating performance counters.
module btb_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             flush,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] cnt_lookup,
  output logic [CNT_W-1:0] cnt_hit,
  output logic [CNT_W-1:0] cnt_mispredict
);
  localparam int IDX = $clog2(ENTRIES);

  logic [ENTRIES-1:0]  r_valid;
  logic [ENTRIES-1:0]  r_jmp;
  logic [TAG_BITS-1:0] r_tag [ENTRIES];
  logic [XLEN-1:0]     r_tgt [ENTRIES];
  logic [1:0]          r_ctr [ENTRIES];
  logic [CNT_W-1:0]    r_cnt_lookup, r_cnt_hit, r_cnt_mispredict;

  logic [IDX-1:0]      w_lidx, w_uidx;
  logic [TAG_BITS-1:0] w_ltag, w_utag;
  logic [1:0]          w_uc, w_ctr;
  logic [XLEN-1:0]     w_tgt;
  logic                w_uhit, w_we;

  assign w_lidx = lookup_pc[IDX+1:2];
  assign w_ltag = lookup_pc[IDX+1+TAG_BITS:IDX+2];
  assign w_uidx = upd_pc[IDX+1:2];
  assign w_utag = upd_pc[IDX+1+TAG_BITS:IDX+2];

  assign pred_hit     = r_valid[w_lidx] & (r_tag[w_lidx] == w_ltag);
  assign pred_taken   = pred_hit & (r_jmp[w_lidx] | r_ctr[w_lidx][1]);
  assign pred_next_pc = pred_taken ? r_tgt[w_lidx] : (lookup_pc & ~XLEN'(3)) + XLEN'(4);

  assign mispredict  = upd_valid & ((upd_taken != upd_pred_taken) |
                                    (upd_taken & (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc & ~XLEN'(3)) + XLEN'(4);

  assign w_uhit = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
  assign w_we   = upd_valid & ~flush & (w_uhit | upd_taken);
  assign w_uc   = r_ctr[w_uidx];

  // Allocation and jump hits both load {1, is_jump}: 11 for jumps, 10 for fresh branches.
  always_comb begin
    w_ctr = (~w_uhit | upd_is_jump) ? {1'b1, upd_is_jump} :
            upd_taken ? ((w_uc == 2'b11) ? 2'b11 : w_uc + 2'b01) :
                        ((w_uc == 2'b00) ? 2'b00 : w_uc - 2'b01);
    w_tgt = (upd_is_jump | upd_taken) ? upd_target : r_tgt[w_uidx];
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_tag[w_uidx] <= w_utag;
      r_tgt[w_uidx] <= w_tgt;
      r_ctr[w_uidx] <= w_ctr;
      r_jmp[w_uidx] <= upd_is_jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid          <= '0;
      r_cnt_lookup     <= '0;
      r_cnt_hit        <= '0;
      r_cnt_mispredict <= '0;
    end else begin
      if (flush) r_valid <= '0;
      else if (w_we) r_valid[w_uidx] <= 1'b1;
      r_cnt_lookup     <= r_cnt_lookup + CNT_W'(lookup_valid & ~&r_cnt_lookup);
      r_cnt_hit        <= r_cnt_hit + CNT_W'(lookup_valid & pred_hit & ~&r_cnt_hit);
      r_cnt_mispredict <= r_cnt_mispredict + CNT_W'(mispredict & ~&r_cnt_mispredict);
    end
  end

  assign cnt_lookup     = r_cnt_lookup;
  assign cnt_hit        = r_cnt_hit;
  assign cnt_mispredict = r_cnt_mispredict;
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: scoreboard bench with a behavioural BTB model; a CNT_W=4 copy
// shares the stimulus to exercise counter saturation.
module tb_btb_predictor;
  localparam int ENTRIES = 64;

  typedef struct {
    logic        hit, tk, mp;
    logic [31:0] npc, rpc, cl, ch, cm;
    logic [3:0]  l4, h4, m4;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic lookup_valid, upd_valid, upd_is_jump, upd_taken, upd_pred_taken, flush;
  logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
  logic pred_hit, pred_taken, mispredict;
  logic [31:0] pred_next_pc, redirect_pc, cnt_lookup, cnt_hit, cnt_mispredict;
  logic p4_hit, p4_taken, mp4;
  logic [31:0] p4_npc, rp4;
  logic [3:0] l4, h4, m4;

  int n_cmp = 0, n_err = 0;
  exp_t sb[$];

  bit          m_valid [ENTRIES];
  bit          m_jmp   [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      c_l, c_h, c_m, c4_l, c4_h, c4_m;

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .cnt_lookup(cnt_lookup), .cnt_hit(cnt_hit), .cnt_mispredict(cnt_mispredict));

  btb_predictor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(p4_hit), .pred_taken(p4_taken), .pred_next_pc(p4_npc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .mispredict(mp4), .redirect_pc(rp4),
    .cnt_lookup(l4), .cnt_hit(h4), .cnt_mispredict(m4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned fidx(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned ftag(input logic [31:0] pc);
    return (pc >> 8) & 32'h3ff;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 0;
    c_l = 0; c_h = 0; c_m = 0; c4_l = 0; c4_h = 0; c4_m = 0;
  endtask

  task automatic idle();
    lookup_valid = 0; lookup_pc = 0; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0; flush = 0;
  endtask

  task automatic compare_out(input string t);
    exp_t e;
    e = sb.pop_front();
    chk({t, ".hit"}, pred_hit, e.hit);
    chk({t, ".taken"}, pred_taken, e.tk);
    chk({t, ".npc"}, pred_next_pc, e.npc);
    chk({t, ".mp"}, mispredict, e.mp);
    chk({t, ".rpc"}, redirect_pc, e.rpc);
    chk({t, ".cnt_lookup"}, cnt_lookup, e.cl);
    chk({t, ".cnt_hit"}, cnt_hit, e.ch);
    chk({t, ".cnt_mp"}, cnt_mispredict, e.cm);
    chk({t, ".c4_lookup"}, l4, e.l4);
    chk({t, ".c4_hit"}, h4, e.h4);
    chk({t, ".c4_mp"}, m4, e.m4);
  endtask

  task automatic step(input string t, input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic uj, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                      input logic fl);
    exp_t e;
    int unsigned li, ui;
    bit uh;
    @(negedge clk);
    lookup_valid = lv; lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_is_jump = uj;
    upd_taken = ut; upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt; flush = fl;
    li = fidx(lpc);
    e.hit = m_valid[li] && m_tag[li] == ftag(lpc);
    e.tk  = e.hit && (m_jmp[li] || m_ctr[li] >= 2);
    e.npc = e.tk ? m_tgt[li] : (lpc & 32'hffff_fffc) + 32'd4;
    e.mp  = uv && ((ut != upt) || (ut && utgt != uptgt));
    e.rpc = ut ? utgt : (upc & 32'hffff_fffc) + 32'd4;
    e.cl = 32'(c_l); e.ch = 32'(c_h); e.cm = 32'(c_m);
    e.l4 = 4'(c4_l); e.h4 = 4'(c4_h); e.m4 = 4'(c4_m);
    sb.push_back(e);
    #1 compare_out(t);
    if (lv) begin c_l = sat(c_l, 32'hffff_ffff); c4_l = sat(c4_l, 15); end
    if (lv && e.hit) begin c_h = sat(c_h, 32'hffff_ffff); c4_h = sat(c4_h, 15); end
    if (e.mp) begin c_m = sat(c_m, 32'hffff_ffff); c4_m = sat(c4_m, 15); end
    ui = fidx(upc);
    uh = m_valid[ui] && m_tag[ui] == ftag(upc);
    if (fl) foreach (m_valid[i]) m_valid[i] = 0;
    else if (uv && uh) begin
      if (uj) begin m_ctr[ui] = 3; m_tgt[ui] = utgt; end
      else if (ut) begin m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3; m_tgt[ui] = utgt; end
      else m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      m_jmp[ui] = uj;
    end else if (uv && ut) begin
      m_valid[ui] = 1; m_tag[ui] = ftag(upc); m_tgt[ui] = utgt; m_jmp[ui] = uj;
      m_ctr[ui] = uj ? 3 : 2;
    end
  endtask

  task automatic look(input string t, input logic [31:0] pc);
    step(t, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input string t, input logic [31:0] pc, input logic ut, input logic [31:0] tgt);
    step(t, 1, pc, 1, pc, 0, ut, tgt, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
    pcs[3] = 32'h104; pcs[4] = 32'h108; pcs[5] = 32'h400;
    idle();
    model_reset();
    lookup_valid = 1; lookup_pc = 32'h100;
    #3;
    chk("rst.hit", pred_hit, 0);
    chk("rst.taken", pred_taken, 0);
    chk("rst.npc", pred_next_pc, 32'h104);
    chk("rst.cnt_lookup", cnt_lookup, 0);
    #4;
    chk("rst.cnt_held", cnt_lookup, 0);
    @(negedge clk);
    idle();
    rst = 0;
    look("t1.miss", 32'h100);
    look("t1.cnt", 32'h100);
    chk("t1.cnt_lookup1", cnt_lookup, 1);
    br("t2.alloc", 32'h100, 1, 32'h40);
    look("t2.hit", 32'h100);
    chk("t2.taken", pred_taken, 1);
    chk("t2.npc", pred_next_pc, 32'h40);
    br("t3.nt1", 32'h100, 0, 0);
    br("t3.nt2", 32'h100, 0, 0);
    br("t3.nt3", 32'h100, 0, 0);
    br("t3.tk1", 32'h100, 1, 32'h40);
    br("t3.tk2", 32'h100, 1, 32'h40);
    look("t3.back", 32'h100);
    chk("t3.taken_again", pred_taken, 1);
    step("t4.jal", 1, 32'h200, 1, 32'h200, 1, 1, 32'h800, 0, 0, 0);
    look("t4.jhit", 32'h200);
    step("t4.jnt", 1, 32'h200, 1, 32'h200, 1, 0, 32'h800, 1, 32'h800, 0);
    look("t4.jstill", 32'h200);
    look("t4.alias", 32'h200 + 4 * ENTRIES);
    br("t4.brhit", 32'h200, 0, 0);
    br("t4.brhit2", 32'h200, 0, 0);
    look("t4.demoted", 32'h200);
    chk("t4.not_taken", pred_taken, 0);
    br("t5.pre", 32'h104, 1, 32'h80);
    step("t5.flush", 1, 32'h104, 1, 32'h300, 0, 1, 32'h900, 0, 0, 1);
    look("t5.m300", 32'h300);
    chk("t5.miss300", pred_hit, 0);
    look("t5.m104", 32'h104);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] u, l;
      u = pcs[$urandom_range(0, 5)];
      l = pcs[$urandom_range(0, 5)];
      step("rnd", 1'($urandom), l, 1'($urandom), u, 1'($urandom_range(0, 3) == 0), 1'($urandom),
           $urandom_range(0, 1) ? 32'h40 : 32'h80, 1'($urandom),
           $urandom_range(0, 1) ? 32'h40 : 32'h80, 1'($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 18; i++) step("t6.mp", 0, 0, 1, 32'h400, 0, 1, 32'h44, 0, 0, 0);
    look("t6.sat", 32'h400);
    chk("t6.c4_mp15", m4, 4'hf);
    #2;
    lookup_valid = 1; lookup_pc = 32'h500; upd_valid = 1; upd_pc = 32'h500;
    upd_taken = 1; upd_target = 32'h60; upd_pred_taken = 0;
    rst = 1;
    #1;
    model_reset();
    chk("t6.rst_hit", pred_hit, 0);
    chk("t6.rst_npc", pred_next_pc, 32'h504);
    chk("t6.rst_cnt_lookup", cnt_lookup, 0);
    chk("t6.rst_cnt_mp", cnt_mispredict, 0);
    chk("t6.rst_c4_mp", m4, 0);
    chk("t6.rst_400miss", dut.r_valid, 0);
    @(negedge clk);
    idle();
    rst = 0;
    look("t6.after", 32'h500);
    look("t6.after400", 32'h400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
